flags_register: RTL

- Holds the 8088 FLAGS word and sits directly downstream of the ALU.
- Captures the ALU's registered flag outputs at the correct pipeline delay and merges them under a per-operation update class.
- Applies direct flag commands: CLC/STC/CMC/CLI/STI/CLD/STD, POPF, SAHF and interrupt entry.
- Supplies CF back to the ALU carry input, with forwarding and a hazard indication.

---
 rtl/flags_register_if.sv | 32 +++
 rtl/flags_register.sv | 126 ++++++++++++
 2 files changed

// File: rtl/flags_register_if.sv
// Bus between the ALU/sequencer side and the FLAGS register: ALU flag
// outputs, issue/class tagging, direct flag commands and the FLAGS readback.
interface flags_register_if;
    logic        aluIssue;
    logic [1:0]  aluClass;
    logic        aluOverflow;
    logic        aluNeg;
    logic        aluZero;
    logic        aluAux;
    logic        aluParity;
    logic        aluCarry;
    logic [3:0]  cmd;
    logic [15:0] dataIn;
    logic [15:0] flags;
    logic        carryOut;
    logic        carryHazard;
    logic        busy;

    modport master (
        output aluIssue, aluClass,
        output aluOverflow, aluNeg, aluZero, aluAux, aluParity, aluCarry,
        output cmd, dataIn,
        input  flags, carryOut, carryHazard, busy
    );

    modport slave (
        input  aluIssue, aluClass,
        input  aluOverflow, aluNeg, aluZero, aluAux, aluParity, aluCarry,
        input  cmd, dataIn,
        output flags, carryOut, carryHazard, busy
    );
endinterface

// File: rtl/flags_register.sv
// 8088 FLAGS register: delayed ALU flag writeback merged by op class, with
// direct flag commands layered on top and CF forwarded back to the ALU.
module flags_register #(
    parameter int          ALU_FLAG_DELAY = 2,
    parameter logic [15:0] RESET_FLAGS    = 16'hF002
) (
    input logic             CLKx4,
    input logic             RESETn,
    flags_register_if.slave bus
);
    localparam int B_CF = 0;
    localparam int B_PF = 2;
    localparam int B_AF = 4;
    localparam int B_ZF = 6;
    localparam int B_SF = 7;
    localparam int B_TF = 8;
    localparam int B_IF = 9;
    localparam int B_DF = 10;
    localparam int B_OF = 11;

    localparam logic [15:0] FIXED_ONES = 16'hF002;
    localparam logic [15:0] WRITABLE   = 16'h0FD5;
    localparam logic [15:0] SAHF_BITS  = 16'h00D5;

    localparam logic [1:0] CLS_NONE  = 2'b00;
    localparam logic [1:0] CLS_ARITH = 2'b01;
    localparam logic [1:0] CLS_NOCF  = 2'b10;
    localparam logic [1:0] CLS_CFOF  = 2'b11;

    typedef enum logic [3:0] {
        CMD_NOP      = 4'd0,
        CMD_CLC      = 4'd1,
        CMD_STC      = 4'd2,
        CMD_CMC      = 4'd3,
        CMD_CLI      = 4'd4,
        CMD_STI      = 4'd5,
        CMD_CLD      = 4'd6,
        CMD_STD      = 4'd7,
        CMD_POPF     = 4'd8,
        CMD_SAHF     = 4'd9,
        CMD_INTENTRY = 4'd10
    } cmd_e;

    logic [15:0]                      flags_q;
    logic [ALU_FLAG_DELAY:1]          vld_pipe;
    logic [ALU_FLAG_DELAY:1][1:0]     cls_pipe;

    logic        wb_vld;
    logic [1:0]  wb_cls;
    logic [15:0] wb_mask;
    logic [15:0] alu_word;
    logic [15:0] merged;
    logic [15:0] nxt;
    logic        carry_fwd;

    assign wb_vld = vld_pipe[ALU_FLAG_DELAY];
    assign wb_cls = cls_pipe[ALU_FLAG_DELAY];

    always_comb begin
        alu_word       = '0;
        alu_word[B_CF] = bus.aluCarry;
        alu_word[B_PF] = bus.aluParity;
        alu_word[B_AF] = bus.aluAux;
        alu_word[B_ZF] = bus.aluZero;
        alu_word[B_SF] = bus.aluNeg;
        alu_word[B_OF] = bus.aluOverflow;
    end

    // Which flag bits the retiring op owns; an empty or class-00 slot owns none.
    always_comb begin
        wb_mask = '0;
        if (wb_vld) begin
            case (wb_cls)
                CLS_ARITH: wb_mask = 16'h08D5;
                CLS_NOCF:  wb_mask = 16'h08D4;
                CLS_CFOF:  wb_mask = 16'h0801;
                default:   wb_mask = '0;
            endcase
        end
    end

    assign merged    = (flags_q & ~wb_mask) | (alu_word & wb_mask);
    assign carry_fwd = wb_mask[B_CF] ? bus.aluCarry : flags_q[B_CF];

    // Commands are applied on top of the merged writeback so they win per bit.
    always_comb begin
        nxt = merged;
        case (cmd_e'(bus.cmd))
            CMD_CLC:      nxt[B_CF] = 1'b0;
            CMD_STC:      nxt[B_CF] = 1'b1;
            CMD_CMC:      nxt[B_CF] = ~carry_fwd;
            CMD_CLI:      nxt[B_IF] = 1'b0;
            CMD_STI:      nxt[B_IF] = 1'b1;
            CMD_CLD:      nxt[B_DF] = 1'b0;
            CMD_STD:      nxt[B_DF] = 1'b1;
            CMD_POPF:     nxt = bus.dataIn;
            CMD_SAHF:     nxt = (merged & ~SAHF_BITS) | ({8'h00, bus.dataIn[7:0]} & SAHF_BITS);
            CMD_INTENTRY: begin
                nxt[B_IF] = 1'b0;
                nxt[B_TF] = 1'b0;
            end
            default:      nxt = merged;
        endcase
    end

    always_ff @(posedge CLKx4) begin
        if (!RESETn) begin
            flags_q  <= (RESET_FLAGS & WRITABLE) | FIXED_ONES;
            vld_pipe <= '0;
            cls_pipe <= '0;
        end else begin
            flags_q     <= (nxt & WRITABLE) | FIXED_ONES;
            vld_pipe[1] <= bus.aluIssue;
            cls_pipe[1] <= bus.aluIssue ? bus.aluClass : CLS_NONE;
            for (int i = 2; i <= ALU_FLAG_DELAY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                cls_pipe[i] <= cls_pipe[i-1];
            end
        end
    end

    assign bus.flags       = flags_q;
    assign bus.carryOut    = carry_fwd;
    assign bus.carryHazard = vld_pipe[1] & ((cls_pipe[1] == CLS_ARITH) | (cls_pipe[1] == CLS_CFOF));
    assign bus.busy        = |vld_pipe;
endmodule
